instruction_fetch: RTL and testbench

Fetch stage of the pipelined ARM core. Owns the program counter, drives the instruction memory's address/read port, and buffers fetched words with their PCs in a 2-entry queue toward decode over a valid/ready handshake. Decode/execute can redirect it on branches, which flushes all buffered instructions.

---
 rtl/arm_core_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 56 +++++
 rtl/instruction_fetch.sv | 85 ++++++++
 tb/tb_instruction_fetch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_core_pkg.sv
// Shared definitions for the pipelined ARM core: datapath widths, reset vector,
// fetch-stage state encoding and the fetch queue entry layout.
package arm_core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [0:0] {
    StBoot,
    StRun
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetched {inst, pc} pairs; flush empties it and
// takes priority over push and pop.
module fetch_queue
  import arm_core_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign head  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  // A push into a full queue is only legal when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues instruction memory reads and buffers fetched
// words in a 2-entry queue toward decode; branches redirect and flush it.
module instruction_fetch
  import arm_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] inst_address,
  output logic            inst_read,
  input  logic [XLEN-1:0] inst_out,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] redirect_target;
  logic            q_full;
  logic            q_empty;
  logic            pop;
  logic            flush;
  fetch_entry_t    push_data;
  fetch_entry_t    head;
  logic [1:0]      unused_redirect_lsb;

  assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = redirect_pc[1:0];

  assign id_valid = !q_empty;
  assign id_inst  = head.inst;
  assign id_pc    = head.pc;

  assign pop   = id_valid && id_ready && !redirect_valid;
  assign flush = redirect_valid;

  // Fetch when a slot is free now or will be freed by this cycle's pop.
  assign inst_read    = (state_q == StRun) && !redirect_valid && (!q_full || (id_valid && id_ready));
  assign inst_address = pc_q;

  assign push_data.inst = inst_out;
  assign push_data.pc   = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
    end else begin
      unique case (state_q)
        StBoot: begin
          state_q <= StRun;
          if (redirect_valid) begin
            pc_q <= redirect_target;
          end
        end
        StRun: begin
          if (redirect_valid) begin
            pc_q <= redirect_target;
          end else if (inst_read) begin
            pc_q <= pc_q + XLEN'(INST_BYTES);
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  fetch_queue u_fetch_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inst_read),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .full      (q_full),
    .empty     (q_empty),
    .head      (head)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: boot, streaming, backpressure, redirect,
// PC wrap-around and asynchronous reset mid-stream.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_address;
  logic        inst_read;
  logic [31:0] inst_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;

  int checks;
  int errors;

  instruction_fetch #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_address   (inst_address),
    .inst_read      (inst_read),
    .inst_out       (inst_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: three fixed words at 0/4/8, elsewhere the inverted address.
  always_comb begin
    case (inst_address)
      32'h0000_0000: inst_out = 32'hE081_5002;
      32'h0000_0004: inst_out = 32'h1919_1919;
      32'h0000_0008: inst_out = 32'h3300_3300;
      default:       inst_out = ~inst_address;
    endcase
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset asserted for two cycles, released at a falling edge; leaves us in BOOT.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (id_valid !== 1'b0 || inst_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: id_valid=%b inst_read=%b required 0 0", id_valid, inst_read);
    end
    checks++;
    if (inst_address !== 32'h0 || id_inst !== 32'h0 || id_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h id_inst=%h id_pc=%h required 0 0 0",
               inst_address, id_inst, id_pc);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (inst_read !== 1'b0) begin
      errors++;
      $display("FAIL boot_no_fetch: inst_read=%b required 0", inst_read);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_inst [3];
    exp_inst[0] = 32'hE081_5002;
    exp_inst[1] = 32'h1919_1919;
    exp_inst[2] = 32'h3300_3300;
    step();
    checks++;
    if (inst_read !== 1'b1 || inst_address !== 32'h0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL run_first_fetch: read=%b addr=%h id_valid=%b required 1 0 0",
               inst_read, inst_address, id_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (id_valid !== 1'b1 || id_inst !== exp_inst[i] || id_pc !== 32'(i * 4)) begin
        errors++;
        $display("FAIL stream_%0d: valid=%b inst=%h pc=%h required 1 %h %h",
                 i, id_valid, id_inst, id_pc, exp_inst[i], 32'(i * 4));
      end
    end
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0;
    do_reset();
    step();
    step();
    step();
    checks++;
    if (inst_read !== 1'b0 || inst_address !== 32'h8 || id_pc !== 32'h0) begin
      errors++;
      $display("FAIL bp_full: read=%b addr=%h id_pc=%h required 0 8 0",
               inst_read, inst_address, id_pc);
    end
    step();
    checks++;
    if (inst_address !== 32'h8 || id_inst !== 32'hE081_5002 || id_pc !== 32'h0) begin
      errors++;
      $display("FAIL bp_hold: addr=%h inst=%h pc=%h required 8 e0815002 0",
               inst_address, id_inst, id_pc);
    end
    id_ready = 1'b1;
    #1;
    checks++;
    if (inst_read !== 1'b1 || id_pc !== 32'h0) begin
      errors++;
      $display("FAIL bp_resume: read=%b id_pc=%h required 1 0", inst_read, id_pc);
    end
    step();
    checks++;
    if (id_pc !== 32'h4 || id_inst !== 32'h1919_1919 || inst_address !== 32'hC) begin
      errors++;
      $display("FAIL bp_pop2: pc=%h inst=%h addr=%h required 4 19191919 c",
               id_pc, id_inst, inst_address);
    end
  endtask

  // Queue stays full while popping and pushing each cycle; order must hold.
  task automatic test_back_to_back();
    step();
    checks++;
    if (id_pc !== 32'h8 || id_inst !== 32'h3300_3300 || inst_read !== 1'b1) begin
      errors++;
      $display("FAIL b2b_0: pc=%h inst=%h read=%b required 8 33003300 1",
               id_pc, id_inst, inst_read);
    end
    step();
    checks++;
    if (id_pc !== 32'hC || id_inst !== 32'hFFFF_FFF3 || inst_address !== 32'h14) begin
      errors++;
      $display("FAIL b2b_1: pc=%h inst=%h addr=%h required c fffffff3 14",
               id_pc, id_inst, inst_address);
    end
    id_ready = 1'b0;
    #1;
    checks++;
    if (inst_read !== 1'b0) begin
      errors++;
      $display("FAIL b2b_still_full: inst_read=%b required 0", inst_read);
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0042;
    #1;
    checks++;
    if (inst_read !== 1'b0) begin
      errors++;
      $display("FAIL redir_no_read: inst_read=%b required 0", inst_read);
    end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || inst_address !== 32'h40 || inst_read !== 1'b1) begin
      errors++;
      $display("FAIL redir_n1: valid=%b addr=%h read=%b required 0 40 1",
               id_valid, inst_address, inst_read);
    end
    id_ready = 1'b1;
    step();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_inst !== 32'hFFFF_FFBF) begin
      errors++;
      $display("FAIL redir_n2: valid=%b pc=%h inst=%h required 1 40 ffffffbf",
               id_valid, id_pc, id_inst);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (inst_address !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_target: addr=%h required fffffffc", inst_address);
    end
    step();
    checks++;
    if (inst_address !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_inst !== 32'h3) begin
      errors++;
      $display("FAIL wrap_next: addr=%h pc=%h inst=%h required 0 fffffffc 3",
               inst_address, id_pc, id_inst);
    end
    step();
    checks++;
    if (id_pc !== 32'h0 || id_inst !== 32'hE081_5002) begin
      errors++;
      $display("FAIL wrap_zero: pc=%h inst=%h required 0 e0815002", id_pc, id_inst);
    end
  endtask

  task automatic test_async_reset();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || inst_read !== 1'b0 || inst_address !== 32'h0) begin
      errors++;
      $display("FAIL async_rst: valid=%b read=%b addr=%h required 0 0 0",
               id_valid, inst_read, inst_address);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (inst_read !== 1'b1 || inst_address !== 32'h0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_restart: read=%b addr=%h valid=%b required 1 0 0",
               inst_read, inst_address, id_valid);
    end
    step();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== 32'hE081_5002) begin
      errors++;
      $display("FAIL async_first: valid=%b pc=%h inst=%h required 1 0 e0815002",
               id_valid, id_pc, id_inst);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
